blocking_in_sequencer: RTL and testbench
========================================

# blocking_in_sequencer

Parametrised multi-channel blocking-input collector with sync/notify handshakes on every port. It reads one word from each of CHANNELS input channels per round, accumulates them into an internal variable that starts from a programmable initial value, then emits the result on a blocking output port. It generalises the two-input blocking-read skeleton to N channels, configurable width, and an optional round-robin ready-first read order.

## Interface

Parameters:
- WIDTH, 32: data width of every channel and of the accumulator (signed).
- CHANNELS, 2: number of blocking input channels (2..16).
- VAR_INIT, 4: accumulator value loaded at reset and after each output transfer.
- MODE, 0: 0 = strict index order; 1 = round-robin, ready-first.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ch_in  in  CHANNELS×WIDTH  per-channel input data.
- ch_in_sync  in  CHANNELS  partner has valid data on channel i.
- ch_in_notify  out  CHANNELS  block is ready to take channel i.
- res_out  out  WIDTH  accumulated result.
- res_out_sync  in  1  consumer ready.
- res_out_notify  out  1  res_out valid and offered.
- nb_result  out  1  sticky signed-overflow flag for the current round.

## Operation

- Transfer on channel i happens at a rising clk edge where ch_in_notify[i] && ch_in_sync[i]. Output transfer happens at an edge where res_out_notify && res_out_sync.
- States: READ, WRITE.
- READ:
  - On a transfer from channel i: var <= var + ch_in[i] (two's complement, wraps mod 2^WIDTH). Set pending[i] <= 0.
  - Signed overflow on the add sets nb_result.
  - When the last pending channel transfers, go to WRITE.
- WRITE:
  - res_out_notify = 1 and res_out = var.
  - On transfer: var <= VAR_INIT, pending <= all ones, nb_result <= 0, state <= READ.
- MODE 0:
  - ch_in_notify is registered and one-hot on idx.
  - idx counts 0..CHANNELS-1. After the transfer on the last channel, idx wraps to 0.
  - No notify is asserted in WRITE.
- MODE 1:
  - ch_in_notify is combinational: a one-hot grant to the first channel with pending && sync, searching from rr_ptr upward with wrap.
  - After a grant to channel i, rr_ptr <= i+1 mod CHANNELS.
  - At most one transfer per cycle. Each channel transfers exactly once per round.
- Sync on a channel that is not notified is ignored. The partner must hold data and sync until it sees notify.

## Timing

- Reset values:
  - state = READ, var = VAR_INIT, pending = all ones, idx = 0, rr_ptr = 0.
  - nb_result = 0, res_out = 0, res_out_notify = 0.
  - ch_in_notify = 1 on bit 0 only in MODE 0. In MODE 1 it is all zero while rst is high.
- At most one input word is consumed per cycle. Minimum round latency is CHANNELS cycles of READ plus 1 cycle to the first res_out_notify.
- res_out_notify rises the cycle after the final read and holds until the output transfer. It falls the cycle after that transfer.
- Mode 0 notify moves to idx+1 the cycle after the transfer on idx.
- Reset asserted mid-round discards the partial sum and pending mask immediately. A held output word is dropped.
- In the same cycle as the last read, res_out_sync has no effect because notify is not yet high.

## Structure

- Shared package blocking_seq_types holds:
  - the state enum (READ, WRITE);
  - MODE_STRICT = 0 and MODE_RR = 1;
  - a channel-index width function clog2(CHANNELS).
- Sub-module rr_grant (CHANNELS): a combinational one-hot first-set search from a start pointer with wrap. It is used only when MODE = 1 and is generated out otherwise.

## Test plan

- Reset, MODE 0, CHANNELS 2 -> ch_in_notify = 2'b01, res_out_notify = 0, nb_result = 0.
- MODE 0, feed 10 and 20 with sync held high -> reads on consecutive cycles, res_out = 34 one cycle later, then var reloads 4.
- MODE 0, CHANNELS 2, WIDTH 32, feed 0x7FFFFFFF and 1 -> res_out = 0x80000004 and nb_result = 1. After the output transfer nb_result = 0.
- MODE 1, CHANNELS 4, sync on channels 2 and 3 only -> channel 2 is granted first and channel 3 next. Channels 0 and 1 are granted once they sync. res_out = 4 plus the sum of the four inputs.
- Output stall: hold res_out_sync = 0 for 5 cycles -> res_out_notify stays high, res_out is stable, and no input notify is asserted.
- Reset asserted after 1 of 3 reads -> the next round sums from 4 and starts at channel 0.

Source files
------------

// File: rtl/blocking_in_sequencer_pkg.sv
// Shared types for the blocking-input sequencer.
//   seq_state_e  : READ (collecting input words) / WRITE (offering the result)
//   MODE_STRICT  : channels are read in fixed index order
//   MODE_RR      : channels are read round-robin, ready-first
//   clog2()      : width of a channel index
package blocking_seq_types;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } seq_state_e;

    localparam int MODE_STRICT = 0;
    localparam int MODE_RR     = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/blocking_in_sequencer_rr_grant.sv
// One-hot first-set search over req, starting at start and wrapping.
//   req      in  CHANNELS  request vector
//   start    in  IW        index searched first
//   gnt      out CHANNELS  one-hot grant (zero when no request)
//   gnt_idx  out IW        index of the granted bit (0 when no grant)
module rr_grant
    import blocking_seq_types::*;
#(
    parameter int CHANNELS = 4,
    localparam int IW = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IW-1:0]       start,
    output logic [CHANNELS-1:0] gnt,
    output logic [IW-1:0]       gnt_idx
);

    always_comb begin
        int          pos;
        logic [IW-1:0] j;
        logic        found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        j       = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            pos = int'(start) + k;
            if (pos >= CHANNELS) pos = pos - CHANNELS;
            j = pos[IW-1:0];
            if (!found && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = j;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/blocking_in_sequencer.sv
// Collects one word from each of CHANNELS blocking input channels per round,
// accumulates them onto VAR_INIT and offers the sum on a blocking output.
//   clk, rst         clock; asynchronous active-high reset
//   ch_in            CHANNELS packed words, channel 0 in the low bits
//   ch_in_sync       partner has data on channel i
//   ch_in_notify     block takes channel i this cycle (if synced)
//   res_out          accumulated result (zero outside WRITE)
//   res_out_sync     consumer ready
//   res_out_notify   res_out valid
//   nb_result        sticky signed overflow of the current round
//
// state | meaning
// READ  | taking one word per cycle until every channel of the round is in
// WRITE | result offered; reload and return to READ on output transfer
module blocking_in_sequencer
    import blocking_seq_types::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    parameter int VAR_INIT = 4,
    parameter int MODE     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] ch_in,
    input  logic [CHANNELS-1:0]       ch_in_sync,
    output logic [CHANNELS-1:0]       ch_in_notify,
    output logic [WIDTH-1:0]          res_out,
    input  logic                      res_out_sync,
    output logic                      res_out_notify,
    output logic                      nb_result
);

    localparam int IW = clog2(CHANNELS);

    seq_state_e                state_q, state_d;
    logic signed [WIDTH-1:0]   var_q, var_d;
    logic [CHANNELS-1:0]       pending_q, pending_d;
    logic [IW-1:0]             ptr_q, ptr_d;
    logic                      nb_q, nb_d;
    logic [CHANNELS-1:0]       notify_q, notify_d;

    logic signed [WIDTH-1:0]   ch_word [CHANNELS];
    logic [IW-1:0]             sel;
    logic signed [WIDTH-1:0]   din;
    logic signed [WIDTH-1:0]   sum;
    logic                      ovf;
    logic                      xfer;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_split
        assign ch_word[i] = ch_in[i*WIDTH +: WIDTH];
    end

    // ptr_q serves as idx in strict mode and rr_ptr in round-robin mode.
    // Both advance to (granted channel + 1) mod CHANNELS on every read, so
    // one register covers either mode.
    if (MODE == MODE_RR) begin : g_rr
        logic [CHANNELS-1:0] req;
        logic [CHANNELS-1:0] gnt;
        logic [IW-1:0]       gnt_idx;

        assign req = (state_q == READ && !rst) ? (pending_q & ch_in_sync) : '0;

        rr_grant #(.CHANNELS(CHANNELS)) u_grant (
            .req     (req),
            .start   (ptr_q),
            .gnt     (gnt),
            .gnt_idx (gnt_idx)
        );

        assign ch_in_notify = gnt;
        assign sel          = gnt_idx;
    end else begin : g_strict
        assign ch_in_notify = notify_q;
        assign sel          = ptr_q;
    end

    assign din  = ch_word[sel];
    assign sum  = var_q + din;
    assign ovf  = (var_q[WIDTH-1] == din[WIDTH-1]) && (sum[WIDTH-1] != var_q[WIDTH-1]);
    assign xfer = (state_q == READ) && |(ch_in_notify & ch_in_sync);

    assign res_out_notify = (state_q == WRITE);
    assign res_out        = (state_q == WRITE) ? var_q : '0;
    assign nb_result      = nb_q;

    always_comb begin
        state_d   = state_q;
        var_d     = var_q;
        pending_d = pending_q;
        ptr_d     = ptr_q;
        nb_d      = nb_q;
        notify_d  = '0;
        case (state_q)
            READ: begin
                if (xfer) begin
                    var_d          = sum;
                    nb_d           = nb_q | ovf;
                    pending_d[sel] = 1'b0;
                    ptr_d          = (sel == IW'(CHANNELS - 1)) ? '0 : sel + 1'b1;
                    if (pending_d == '0) state_d = WRITE;
                end
            end
            WRITE: begin
                if (res_out_sync) begin
                    var_d     = WIDTH'(VAR_INIT);
                    pending_d = '1;
                    nb_d      = 1'b0;
                    state_d   = READ;
                end
            end
            default: state_d = READ;
        endcase
        // Strict-mode notify is registered: it points at the next index to read.
        if (state_d == READ) notify_d[ptr_d] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= READ;
            var_q     <= WIDTH'(VAR_INIT);
            pending_q <= '1;
            ptr_q     <= '0;
            nb_q      <= 1'b0;
            notify_q  <= (MODE == MODE_STRICT) ? CHANNELS'(1) : '0;
        end else begin
            state_q   <= state_d;
            var_q     <= var_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            nb_q      <= nb_d;
            notify_q  <= notify_d;
        end
    end

endmodule

// File: tb/tb_blocking_in_sequencer.sv
module tb_blocking_in_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut0: strict, 2 channels
    logic [63:0]  ch_in0 = '0;
    logic [1:0]   sync0 = '0, not0;
    logic [31:0]  res0;
    logic         rsync0 = 1'b0, rnot0, nb0;
    // dut1: round-robin, 4 channels
    logic [127:0] ch_in1 = '0;
    logic [3:0]   sync1 = '0, not1;
    logic [31:0]  res1;
    logic         rsync1 = 1'b0, rnot1, nb1;
    // dut2: strict, 3 channels
    logic [95:0]  ch_in2 = '0;
    logic [2:0]   sync2 = '0, not2;
    logic [31:0]  res2;
    logic         rsync2 = 1'b0, rnot2, nb2;

    blocking_in_sequencer #(.WIDTH(32), .CHANNELS(2), .VAR_INIT(4), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .ch_in(ch_in0), .ch_in_sync(sync0), .ch_in_notify(not0),
        .res_out(res0), .res_out_sync(rsync0), .res_out_notify(rnot0), .nb_result(nb0));
    blocking_in_sequencer #(.WIDTH(32), .CHANNELS(4), .VAR_INIT(4), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .ch_in(ch_in1), .ch_in_sync(sync1), .ch_in_notify(not1),
        .res_out(res1), .res_out_sync(rsync1), .res_out_notify(rnot1), .nb_result(nb1));
    blocking_in_sequencer #(.WIDTH(32), .CHANNELS(3), .VAR_INIT(4), .MODE(0)) dut2 (
        .clk(clk), .rst(rst), .ch_in(ch_in2), .ch_in_sync(sync2), .ch_in_notify(not2),
        .res_out(res2), .res_out_sync(rsync2), .res_out_notify(rnot2), .nb_result(nb2));

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] q0[$], q1[$], q2[$];   // {nb, result}
    logic [32:0] e0, e1, e2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference accumulate: 33-bit sign-extended add, overflow when the
    // two top bits of the wide sum disagree.
    function automatic logic [32:0] acc(input logic [32:0] st, input logic [31:0] x);
        logic [32:0] full;
        full = {st[31], st[31:0]} + {x[31], x};
        return {st[32] | (full[32] ^ full[31]), full[31:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) if (!rst && rnot0 && rsync0) begin
        if (q0.size() == 0) chk("sb0_empty", 64'(q0.size()), 64'd1);
        else begin
            e0 = q0.pop_front();
            chk("sb0_res", res0, e0[31:0]);
            chk("sb0_nb", nb0, e0[32]);
        end
    end
    always @(negedge clk) if (!rst && rnot1 && rsync1) begin
        if (q1.size() == 0) chk("sb1_empty", 64'(q1.size()), 64'd1);
        else begin
            e1 = q1.pop_front();
            chk("sb1_res", res1, e1[31:0]);
            chk("sb1_nb", nb1, e1[32]);
        end
    end
    always @(negedge clk) if (!rst && rnot2 && rsync2) begin
        if (q2.size() == 0) chk("sb2_empty", 64'(q2.size()), 64'd1);
        else begin
            e2 = q2.pop_front();
            chk("sb2_res", res2, e2[31:0]);
            chk("sb2_nb", nb2, e2[32]);
        end
    end

    task automatic round0(input logic [31:0] a, input logic [31:0] b, input bit stall);
        logic [32:0] e;
        e = acc(acc({1'b0, 32'd4}, a), b);
        q0.push_back(e);
        ch_in0 = {b, a};
        sync0  = 2'b11;
        rsync0 = !stall;
        step();
        chk("m0_adv", not0, 2'b10);
        chk("m0_rnot_lo", rnot0, 1'b0);
        step();
        sync0 = 2'b00;
        chk("m0_rnot_hi", rnot0, 1'b1);
        chk("m0_res", res0, e[31:0]);
        chk("m0_wr_nonotify", not0, 2'b00);
        if (stall) begin
            repeat (5) begin
                step();
                chk("m0_stall_rnot", rnot0, 1'b1);
                chk("m0_stall_res", res0, e[31:0]);
                chk("m0_stall_nonotify", not0, 2'b00);
            end
            rsync0 = 1'b1;
        end
        step();
        chk("m0_rnot_fall", rnot0, 1'b0);
        chk("m0_restart", not0, 2'b01);
        chk("m0_nb_clr", nb0, 1'b0);
        rsync0 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog n_vec=%0d", n_vec);
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_not0", not0, 2'b01);
        chk("rst_rnot0", rnot0, 1'b0);
        chk("rst_nb0", nb0, 1'b0);
        chk("rst_res0", res0, 32'd0);
        chk("rst_not1", not1, 4'b0000);
        chk("rst_not2", not2, 3'b001);
        @(negedge clk);
        rst = 1'b0;

        // strict mode, 2 channels
        round0(32'd10, 32'd20, 1'b0);
        round0(32'h7FFF_FFFF, 32'd1, 1'b0);
        sync0 = 2'b10;          // sync on a channel that is not notified
        repeat (2) step();
        chk("m0_ignore", not0, 2'b01);
        chk("m0_ignore_rnot", rnot0, 1'b0);
        round0(32'hFFFF_FFFB, 32'd100, 1'b1);

        // round-robin, 4 channels: ch3=7 ch2=-50 ch1=200 ch0=100
        ch_in1 = {32'd7, 32'hFFFF_FFCE, 32'd200, 32'd100};
        q1.push_back(acc(acc(acc(acc({1'b0, 32'd4}, 32'hFFFF_FFCE), 32'd7), 32'd100), 32'd200));
        rsync1 = 1'b1;
        sync1  = 4'b1100;
        #1 chk("rr_first", not1, 4'b0100);
        step();
        chk("rr_second", not1, 4'b1000);
        step();
        chk("rr_idle", not1, 4'b0000);
        sync1 = 4'b1111;
        #1 chk("rr_wrap0", not1, 4'b0001);
        step();
        chk("rr_ch1", not1, 4'b0010);
        step();
        sync1 = 4'b0000;
        chk("rr_rnot", rnot1, 1'b1);
        chk("rr_wr_nonotify", not1, 4'b0000);
        step();
        chk("rr_rnot_fall", rnot1, 1'b0);
        // pointer carries over: next round starts at channel 2
        ch_in1 = {32'd1, 32'd2, 32'd3, 32'hFFFF_FFF6};
        q1.push_back(acc(acc(acc(acc({1'b0, 32'd4}, 32'd2), 32'd1), 32'hFFFF_FFF6), 32'd3));
        sync1 = 4'b1111;
        #1 chk("rr_ptr_keep", not1, 4'b0100);
        repeat (4) step();
        sync1 = 4'b0000;
        chk("rr2_rnot", rnot1, 1'b1);
        step();
        chk("rr2_rnot_fall", rnot1, 1'b0);
        rsync1 = 1'b0;

        // reset after one of three reads
        ch_in2 = {32'd30, 32'd20, 32'd10};
        sync2  = 3'b111;
        rsync2 = 1'b1;
        step();
        chk("rst_mid_adv", not2, 3'b010);
        rst = 1'b1;
        #1;
        chk("rst_mid_notify", not2, 3'b001);
        chk("rst_mid_rnot", rnot2, 1'b0);
        rst = 1'b0;
        q2.push_back(acc(acc(acc({1'b0, 32'd4}, 32'd10), 32'd20), 32'd30));
        step();
        chk("rst_r0", not2, 3'b010);
        step();
        chk("rst_r1", not2, 3'b100);
        step();
        sync2 = 3'b000;
        chk("rst_rnot", rnot2, 1'b1);
        step();
        chk("rst_rnot_fall", rnot2, 1'b0);
        chk("rst_restart", not2, 3'b001);
        rsync2 = 1'b0;

        step();
        chk("sb_drain", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
